// File: rtl/ip_match_table.sv
// Parallel IP address match table with a fixed-latency data alignment pipeline.
// Define IP_MASK_EN to build per-entry prefix masks; otherwise every compare is exact equality.
module ip_match_table #(
   parameter int DATA_W      = 32,
   parameter int NUM_ENTRIES = 4,
   parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
   parameter int DELAY       = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              cfg_we_i,
   input  logic [IDX_W-1:0]  cfg_idx_i,
   input  logic              cfg_valid_i,
   input  logic [DATA_W-1:0] cfg_addr_i,
   input  logic [DATA_W-1:0] cfg_mask_i,
   input  logic              data_valid_i,
   input  logic [DATA_W-1:0] data_in_i,
   output logic [DATA_W-1:0] data_out_o,
   output logic              data_out_valid_o,
   output logic              match_o,
   output logic [IDX_W-1:0]  match_idx_o,
   output logic [7:0]        hit_count_o
);

   logic [NUM_ENTRIES-1:0] ent_valid_q;
   logic [DATA_W-1:0]      ent_addr_q [NUM_ENTRIES];
`ifdef IP_MASK_EN
   logic [DATA_W-1:0]      ent_mask_q [NUM_ENTRIES];
`else
   logic                   unused_mask;
   assign unused_mask = ^cfg_mask_i;
`endif

   // Table writes land at the edge, so a same-cycle compare still sees the old entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ent_valid_q <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_addr_q[i] <= '0;
`ifdef IP_MASK_EN
            ent_mask_q[i] <= '1;
`endif
         end
      end else if (!clear_i && cfg_we_i) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (cfg_idx_i == IDX_W'(i)) begin
               ent_valid_q[i] <= cfg_valid_i;
               ent_addr_q[i]  <= cfg_addr_i;
`ifdef IP_MASK_EN
               ent_mask_q[i]  <= cfg_mask_i;
`endif
            end
         end
      end
   end

   logic [NUM_ENTRIES-1:0] hit_vec;
   logic [IDX_W-1:0]       hit_idx;
   logic                   word_hit;

   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
`ifdef IP_MASK_EN
         hit_vec[i] = ent_valid_q[i] && (((data_in_i ^ ent_addr_q[i]) & ent_mask_q[i]) == '0);
`else
         hit_vec[i] = ent_valid_q[i] && (data_in_i == ent_addr_q[i]);
`endif
      end
   end

   // Descending scan so the lowest hitting index is the one left standing.
   always_comb begin
      hit_idx = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (hit_vec[i]) hit_idx = IDX_W'(i);
      end
   end

   assign word_hit = data_valid_i && !clear_i && (|hit_vec);

   logic             match_q, match_d;
   logic [IDX_W-1:0] match_idx_q, match_idx_d;
   logic [7:0]       hit_count_q, hit_count_d;

   always_comb begin
      match_d     = match_q;
      match_idx_d = match_idx_q;
      hit_count_d = hit_count_q;
      if (word_hit) begin
         match_d = 1'b1;
         if (!match_q) match_idx_d = hit_idx;
         if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         match_q     <= 1'b0;
         match_idx_q <= '0;
         hit_count_q <= '0;
      end else begin
         match_q     <= match_d;
         match_idx_q <= match_idx_d;
         hit_count_q <= hit_count_d;
      end
   end

   logic [DELAY-1:0]  pipe_v_q;
   logic [DATA_W-1:0] pipe_d_q [DELAY];

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         pipe_v_q <= '0;
         for (int i = 0; i < DELAY; i++) pipe_d_q[i] <= '0;
      end else begin
         pipe_v_q[0] <= data_valid_i;
         pipe_d_q[0] <= data_in_i;
         for (int i = 1; i < DELAY; i++) begin
            pipe_v_q[i] <= pipe_v_q[i-1];
            pipe_d_q[i] <= pipe_d_q[i-1];
         end
      end
   end

   assign data_out_o       = pipe_d_q[DELAY-1];
   assign data_out_valid_o = pipe_v_q[DELAY-1];
   assign match_o          = match_q;
   assign match_idx_o      = match_idx_q;
   assign hit_count_o      = hit_count_q;

endmodule

// File: tb/tb_ip_match_table.sv
// Scoreboard bench for ip_match_table: stimulus pushes expected state and data words,
// a negedge monitor pops and compares against the DUT outputs.
module tb_ip_match_table;
   localparam int DW    = 32;
   localparam int NE    = 4;
   localparam int IW    = 2;
   localparam int DELAY = 2;
`ifdef IP_MASK_EN
   localparam bit MASK_EN = 1'b1;
`else
   localparam bit MASK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1, clear = 1'b0, cfg_we = 1'b0, cfg_valid = 1'b0, dvalid = 1'b0;
   logic [IW-1:0] cfg_idx = '0;
   logic [DW-1:0] cfg_addr = '0, cfg_mask = '0, din = '0;
   logic [DW-1:0] dout;
   logic          dout_v, match;
   logic [IW-1:0] match_idx;
   logic [7:0]    hit_count;

   always #5 clk = ~clk;

   ip_match_table #(.DATA_W(DW), .NUM_ENTRIES(NE), .IDX_W(IW), .DELAY(DELAY)) dut (
      .clk_i(clk), .rst_i(rst), .clear_i(clear), .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
      .cfg_valid_i(cfg_valid), .cfg_addr_i(cfg_addr), .cfg_mask_i(cfg_mask),
      .data_valid_i(dvalid), .data_in_i(din), .data_out_o(dout), .data_out_valid_o(dout_v),
      .match_o(match), .match_idx_o(match_idx), .hit_count_o(hit_count));

   typedef struct { int e; logic [DW-1:0] d; } word_t;
   typedef struct { bit m; int idx; int cnt; } state_t;

   word_t  dq[$];
   state_t st_q[$];
   int     edge_n = 0;
   int     n_cmp = 0, n_bad = 0;

   bit            m_valid [NE];
   logic [DW-1:0] m_addr  [NE];
   logic [DW-1:0] m_mask  [NE];
   bit            m_match = 0;
   int            m_idx = 0, m_cnt = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // Reference: lowest valid entry whose compared bits agree with the word.
   function automatic int model_hit(input logic [DW-1:0] d);
      logic [DW-1:0] eff;
      for (int i = 0; i < NE; i++) begin
         eff = MASK_EN ? m_mask[i] : '1;
         if (m_valid[i] && ((d & eff) == (m_addr[i] & eff))) return i;
      end
      return -1;
   endfunction

   task automatic tick();
      int h;
      @(posedge clk);
      edge_n++;
      if (rst || clear) begin
         if (rst) begin
            for (int i = 0; i < NE; i++) begin
               m_valid[i] = 0; m_addr[i] = '0; m_mask[i] = '1;
            end
         end
         m_match = 0; m_idx = 0; m_cnt = 0;
         while (dq.size() > 0 && dq[$].e >= edge_n) void'(dq.pop_back());
      end else begin
         if (dvalid) begin
            h = model_hit(din);
            if (h >= 0) begin
               if (!m_match) begin m_match = 1; m_idx = h; end
               if (m_cnt < 255) m_cnt++;
            end
            dq.push_back('{edge_n + DELAY - 1, din});
         end
         if (cfg_we) begin
            m_valid[cfg_idx] = cfg_valid;
            m_addr[cfg_idx]  = cfg_addr;
            m_mask[cfg_idx]  = cfg_mask;
         end
      end
      st_q.push_back('{m_match, m_idx, m_cnt});
      #1;
      rst = 0; clear = 0; cfg_we = 0; dvalid = 0;
   endtask

   task automatic send(input logic [DW-1:0] d);
      dvalid = 1; din = d;
      tick();
   endtask

   task automatic cfg(input int idx, input logic v, input logic [DW-1:0] a, input logic [DW-1:0] m);
      cfg_we = 1; cfg_idx = IW'(idx); cfg_valid = v; cfg_addr = a; cfg_mask = m;
      tick();
   endtask

   always @(negedge clk) begin
      state_t s;
      bit exp_v;
      if (st_q.size() > 0) begin
         s = st_q.pop_front();
         check("match", {31'd0, match}, {31'd0, s.m});
         check("match_idx", {30'd0, match_idx}, DW'(s.idx));
         check("hit_count", {24'd0, hit_count}, DW'(s.cnt));
         exp_v = (dq.size() > 0) && (dq[0].e == edge_n);
         check("data_out_valid", {31'd0, dout_v}, {31'd0, exp_v});
         if (exp_v) begin
            if (dout_v === 1'b1) check("data_out", dout, dq[0].d);
            void'(dq.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout n_cmp=%0d", n_cmp);
      $fatal(1, "timeout");
   end

   logic [DW-1:0] pool [4];

   initial begin
      pool[0] = 32'h0A000005; pool[1] = 32'hC0A80001;
      pool[2] = 32'hC0A81234; pool[3] = 32'h01020304;
      rst = 1; tick();
      rst = 1; tick();
      check("reset_data_out", dout, '0);
      check("reset_data_out_valid", {31'd0, dout_v}, '0);

      send(32'hC0A80001);
      repeat (DELAY + 1) tick();

      cfg(2, 1, 32'h0A000005, '1);
      send(32'h01020304); send(32'h0A000005); send(32'h0A000005);
      tick();
      check("plan_idx2", {30'd0, match_idx}, 32'd2);
      check("plan_cnt2", {24'd0, hit_count}, 32'd2);

      clear = 1; tick();
      cfg(1, 1, 32'h0A000005, '1);
      cfg(3, 1, 32'h0A000005, '1);
      send(32'h0A000005); tick();
      check("plan_lowest_idx", {30'd0, match_idx}, 32'd1);

      clear = 1; tick();
      cfg(0, 1, 32'hC0A80000, 32'hFFFF0000);
      send(32'hC0A81234); tick();
      check("plan_mask", {31'd0, match}, {31'd0, MASK_EN});

      // clear arriving with a hit word drops that word entirely
      send(32'h0A000005);
      dvalid = 1; din = 32'h0A000005; clear = 1; tick();
      send(32'h0A000005);
      repeat (DELAY) tick();

      clear = 1; tick();
      for (int i = 0; i < 300; i++) send(32'h0A000005);
      tick();
      check("plan_saturate", {24'd0, hit_count}, 32'd255);

      // invalidate the only hitting entry while a hit word is being compared
      clear = 1; tick();
      cfg(2, 0, '0, '1); cfg(3, 0, '0, '1);
      send(32'h0A000005);
      dvalid = 1; din = 32'h0A000005;
      cfg_we = 1; cfg_idx = 2'd1; cfg_valid = 0; cfg_addr = '0; cfg_mask = '1;
      tick();
      send(32'h0A000005);
      tick();
      check("plan_collision_cnt", {24'd0, hit_count}, 32'd2);

      for (int i = 0; i < 500; i++) begin
         dvalid   = ($urandom_range(0, 3) != 0);
         din      = ($urandom_range(0, 7) == 0) ? $urandom : pool[$urandom_range(0, 3)];
         cfg_we   = ($urandom_range(0, 7) == 0);
         cfg_idx  = IW'($urandom_range(0, NE - 1));
         cfg_valid = ($urandom_range(0, 3) != 0);
         cfg_addr = pool[$urandom_range(0, 3)];
         case ($urandom_range(0, 3))
            0: cfg_mask = 32'hFFFFFFFF;
            1: cfg_mask = 32'hFFFF0000;
            2: cfg_mask = 32'hFFFFFF00;
            default: cfg_mask = 32'h00000000;
         endcase
         clear    = ($urandom_range(0, 31) == 0);
         rst      = ($urandom_range(0, 199) == 0);
         tick();
      end

      repeat (DELAY + 2) tick();
      #10;
      check("data_queue_drained", DW'(dq.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
